// File: rtl/sched_pkg.sv
// Shared types and helpers for the round-robin grant scheduler.
package sched_pkg;

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_GRANT = 1'b1
    } state_t;

    function automatic int req_count(input int n);
        return 1 << n;
    endfunction

endpackage

// File: rtl/rr_grant_scheduler_if.sv
// Request/grant bundle between requesters (master) and the scheduler (slave).
interface rr_grant_scheduler_if
    import sched_pkg::*;
#(
    parameter int N = 3
);
    localparam int W = req_count(N);

    logic         enable;
    logic [W-1:0] req;
    logic         ack;
    logic         grant_valid;
    logic [N-1:0] grant_idx;
    logic [W-1:0] grant_onehot;
    logic         timeout;
    logic [W-1:0] pending;

    modport master (
        output enable, req, ack,
        input  grant_valid, grant_idx, grant_onehot, timeout, pending
    );

    modport slave (
        input  enable, req, ack,
        output grant_valid, grant_idx, grant_onehot, timeout, pending
    );
endinterface

// File: rtl/lsb_index_encoder.sv
// Combinational encoder: index of the lowest set bit, plus an any-set flag.
module lsb_index_encoder
    import sched_pkg::*;
#(
    parameter int N = 3
) (
    input  logic [req_count(N)-1:0] in,
    output logic [N-1:0]            idx,
    output logic                    any
);
    always_comb begin
        idx = '0;
        any = 1'b0;
        // Scan downward so the last hit is the lowest set bit.
        for (int i = req_count(N) - 1; i >= 0; i--) begin
            if (in[i]) begin
                idx = N'(i);
                any = 1'b1;
            end
        end
    end
endmodule

// File: rtl/rr_grant_scheduler.sv
// Round-robin scheduler: sticky pending requests, rotating fairness pointer,
// grant held until ack, enable drop, or timeout.
//
// state    | meaning
// ST_IDLE  | no grant; picks next pending requester when enabled
// ST_GRANT | grant_idx owns the resource; waiting for ack or timeout
module rr_grant_scheduler
    import sched_pkg::*;
#(
    parameter int N       = 3,
    parameter int TIMEOUT = 15
) (
    input logic                 clk,
    input logic                 rst_n,
    rr_grant_scheduler_if.slave bus
);
    localparam int W  = req_count(N);
    localparam int TW = $clog2(TIMEOUT + 1);

    state_t         state, state_next;
    logic [N-1:0]   grant_idx, grant_idx_next;
    logic [N-1:0]   ptr, ptr_next;
    logic [N-1:0]   off, sel_idx;
    logic           sel_any;
    logic           timeout, timeout_next;
    logic [W-1:0]   pending, pending_next, clr, rotated;
    logic [2*W-1:0] rot_dbl;
    logic [TW-1:0]  timer, timer_next;
    logic           expire;

    assign rot_dbl = {pending, pending} >> ptr;
    assign rotated = rot_dbl[W-1:0];
    assign sel_idx = ptr + off;
    assign expire  = (timer == TW'(TIMEOUT - 1));

    lsb_index_encoder #(.N(N)) u_enc (
        .in  (rotated),
        .idx (off),
        .any (sel_any)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= ST_IDLE;
            grant_idx <= '0;
            ptr       <= '0;
            timer     <= '0;
            timeout   <= 1'b0;
            pending   <= '0;
        end else begin
            state     <= state_next;
            grant_idx <= grant_idx_next;
            ptr       <= ptr_next;
            timer     <= timer_next;
            timeout   <= timeout_next;
            pending   <= pending_next;
        end
    end

    always_comb begin
        state_next     = state;
        grant_idx_next = grant_idx;
        ptr_next       = ptr;
        timer_next     = timer;
        timeout_next   = 1'b0;
        clr            = '0;
        case (state)
            ST_IDLE: begin
                if (bus.enable && sel_any) begin
                    grant_idx_next = sel_idx;
                    timer_next     = '0;
                    state_next     = ST_GRANT;
                end
            end
            ST_GRANT: begin
                if (!bus.enable) begin
                    state_next = ST_IDLE;
                end else if (bus.ack) begin
                    clr        = W'(1) << grant_idx;
                    ptr_next   = grant_idx + 1'b1;
                    state_next = ST_IDLE;
                end else if (expire) begin
                    timeout_next = 1'b1;
                    ptr_next     = grant_idx + 1'b1;
                    state_next   = ST_IDLE;
                end else begin
                    timer_next = timer + 1'b1;
                end
            end
            default: state_next = ST_IDLE;
        endcase
        // A new request on the bit being cleared wins.
        pending_next = (pending & ~clr) | bus.req;
    end

    always_comb begin
        bus.grant_valid  = (state == ST_GRANT);
        bus.grant_idx    = grant_idx;
        bus.timeout      = timeout;
        bus.pending      = pending;
        bus.grant_onehot = (state == ST_GRANT) ? (W'(1) << grant_idx) : '0;
    end
endmodule

// File: tb/tb_rr_grant_scheduler.sv
// Scoreboard bench for rr_grant_scheduler: behavioural model feeds queues,
// a negedge monitor compares DUT outputs against them.
module tb_rr_grant_scheduler;
    localparam int N  = 3;
    localparam int W  = 1 << N;
    localparam int TO = 4;

    logic clk = 1'b0;
    logic rst_n = 1'b0;

    rr_grant_scheduler_if #(.N(N)) bus ();

    rr_grant_scheduler #(.N(N), .TIMEOUT(TO)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string name, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    typedef struct {
        bit         gv;
        int         idx;
        bit [W-1:0] pend;
        bit         tmo;
    } snap_t;
    typedef struct {
        bit is_tmo;
        int idx;
    } ev_t;

    snap_t snap_q[$];
    ev_t   ev_q[$];

    bit         m_hold = 0;
    int         m_idx  = 0;
    int         m_ptr  = 0;
    int         m_held = 0;
    bit [W-1:0] m_pend = '0;
    bit         m_tmo  = 0;
    bit [W-1:0] m_np;
    bit         m_acc;
    bit         m_found;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_hold = 0; m_idx = 0; m_ptr = 0; m_held = 0; m_pend = '0; m_tmo = 0;
            snap_q.delete();
            ev_q.delete();
        end else begin
            m_acc = m_hold && bus.enable && bus.ack;
            for (int i = 0; i < W; i++)
                m_np[i] = (m_pend[i] && !(m_acc && i == m_idx)) || bus.req[i];
            m_tmo = 0;
            if (!m_hold) begin
                if (bus.enable && m_pend != 0) begin
                    m_found = 0;
                    for (int k = 0; k < W; k++) begin
                        if (!m_found && m_pend[(m_ptr + k) % W]) begin
                            m_idx   = (m_ptr + k) % W;
                            m_found = 1;
                        end
                    end
                    m_hold = 1;
                    m_held = 0;
                    ev_q.push_back('{is_tmo: 1'b0, idx: m_idx});
                end
            end else if (!bus.enable) begin
                m_hold = 0;
            end else if (bus.ack) begin
                m_hold = 0;
                m_ptr  = (m_idx + 1) % W;
            end else if (m_held == TO - 1) begin
                m_hold = 0;
                m_tmo  = 1;
                m_ptr  = (m_idx + 1) % W;
                ev_q.push_back('{is_tmo: 1'b1, idx: m_idx});
            end else begin
                m_held++;
            end
            m_pend = m_np;
            snap_q.push_back('{gv: m_hold, idx: m_idx, pend: m_pend, tmo: m_tmo});
        end
    end

    // ---------------- monitor ----------------
    int    dut_grants[$];
    int    n_tmo_seen = 0;
    bit    prev_gv = 0;
    snap_t s;
    ev_t   e;

    always @(negedge clk) begin
        if (!rst_n) begin
            prev_gv = 0;
        end else begin
            if (snap_q.size() == 0) begin
                check("snapshot_available", 0, 1);
            end else begin
                s = snap_q.pop_front();
                check("grant_valid", int'(bus.grant_valid), int'(s.gv));
                check("grant_idx", int'(bus.grant_idx), s.idx);
                check("pending", int'(bus.pending), int'(s.pend));
                check("timeout", int'(bus.timeout), int'(s.tmo));
                check("grant_onehot", int'(bus.grant_onehot), s.gv ? (1 << s.idx) : 0);
            end
            if (bus.grant_valid && !prev_gv) begin
                dut_grants.push_back(int'(bus.grant_idx));
                if (ev_q.size() == 0) check("grant_event_expected", 0, 1);
                else begin
                    e = ev_q.pop_front();
                    check("grant_event_idx", int'(bus.grant_idx), e.is_tmo ? 99 : e.idx);
                end
            end
            if (bus.timeout) begin
                n_tmo_seen++;
                if (ev_q.size() == 0) check("timeout_event_expected", 0, 1);
                else begin
                    e = ev_q.pop_front();
                    check("timeout_event_idx", int'(bus.grant_idx), e.is_tmo ? e.idx : 99);
                end
            end
            prev_gv = bus.grant_valid;
        end
    end

    // ---------------- stimulus ----------------
    int ack_at = -1;   // -1 random, -2 never, else ack when held count matches

    task automatic step(input bit en, input logic [W-1:0] rq);
        bus.enable = en;
        bus.req    = rq;
        if (ack_at == -1)      bus.ack = ($urandom_range(0, 2) == 0);
        else if (ack_at == -2) bus.ack = 1'b0;
        else                   bus.ack = m_hold && (m_held == ack_at);
        @(negedge clk);
    endtask

    task automatic do_reset();
        #1 rst_n = 1'b0;
        bus.enable = 1'b0; bus.req = '0; bus.ack = 1'b0;
        @(negedge clk);
        #1 rst_n = 1'b1;
        dut_grants.delete();
        n_tmo_seen = 0;
    endtask

    task automatic check_seq(input string name, input int exp[$]);
        check({name, "_count"}, int'(dut_grants.size() >= exp.size()), 1);
        for (int i = 0; i < exp.size(); i++)
            if (i < dut_grants.size()) check(name, dut_grants[i], exp[i]);
    endtask

    int exp_q[$];

    initial begin
        bus.enable = 1'b0;
        bus.req    = '0;
        bus.ack    = 1'b0;
        repeat (3) @(negedge clk);
        check("reset_grant_valid", int'(bus.grant_valid), 0);
        check("reset_pending", int'(bus.pending), 0);
        check("reset_grant_idx", int'(bus.grant_idx), 0);
        #1 rst_n = 1'b1;

        // Two one-shot requests, ack on second grant cycle: 2 then 5.
        ack_at = 1;
        step(1, 8'b0010_0100);
        repeat (12) step(1, '0);
        exp_q = {2, 5};
        check_seq("seq_two_shot", exp_q);

        // Held requests on 0 and 7 alternate.
        do_reset();
        ack_at = 0;
        repeat (10) step(1, 8'b1000_0001);
        exp_q = {0, 7, 0, 7};
        check_seq("seq_fairness", exp_q);

        // Timeout on 3 moves pointer past it, so 1 goes next.
        do_reset();
        ack_at = -2;
        step(1, 8'b0000_1000);
        step(1, '0);
        step(1, 8'b0000_0010);
        repeat (8) step(1, '0);
        exp_q = {3, 1};
        check_seq("seq_timeout", exp_q);
        check("timeout_seen", int'(n_tmo_seen >= 1), 1);

        // Randomized traffic.
        do_reset();
        ack_at = -1;
        for (int c = 0; c < 600; c++)
            step($urandom_range(0, 9) != 0,
                 ($urandom_range(0, 2) == 0) ? W'($urandom) : W'(0));

        // Enable drop mid-grant, regrant, then async reset mid-grant.
        do_reset();
        ack_at = -2;
        step(1, 8'b0001_0000);
        for (int c = 0; c < 20 && !m_hold; c++) step(1, '0);
        check("grant_reached", int'(m_hold), 1);
        step(0, '0);
        for (int c = 0; c < 20 && !m_hold; c++) step(1, '0);
        #2;
        check("pre_reset_grant_valid", int'(bus.grant_valid), 1);
        check("pre_reset_pending", int'(bus.pending), 8'b0001_0000);
        rst_n = 1'b0;
        #1;
        check("async_rst_grant_valid", int'(bus.grant_valid), 0);
        check("async_rst_onehot", int'(bus.grant_onehot), 0);
        check("async_rst_pending", int'(bus.pending), 0);
        check("async_rst_grant_idx", int'(bus.grant_idx), 0);
        check("async_rst_timeout", int'(bus.timeout), 0);
        @(negedge clk);
        #1 rst_n = 1'b1;
        repeat (4) step(1, '0);
        check("events_drained", ev_q.size(), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule

// File: doc/rr_grant_scheduler.md
# rr_grant_scheduler

Round-robin scheduler that shares one downstream resource between 2**N requesters. Requests are latched into a sticky pending register. A lowest-set-bit encoder, applied to the pending vector rotated by a fairness pointer, selects the next requester. The grant is held until the requester acknowledges or a timeout expires. The block sits between the request sources and the shared resource and drives the resource's index select with `grant_idx`.

## Interface
- `N`, 3, index width; requester count is 2**N.
- `TIMEOUT`, 15, maximum cycles a grant is held without `ack`; minimum 1.
- `clk`  in  1  single clock, rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `enable`  in  1  scheduler enable; low blocks new grants and aborts an active grant.
- `req`  in  2**N  request pulses or levels, one bit per requester.
- `ack`  in  1  holder releases the resource; only meaningful while `grant_valid`.
- `grant_valid`  out  1  a grant is active.
- `grant_idx`  out  N  index of the granted requester.
- `grant_onehot`  out  2**N  one-hot form of `grant_idx`; all zero when no grant is active.
- `timeout`  out  1  one-cycle pulse when a grant is dropped for lack of `ack`.
- `pending`  out  2**N  current sticky request register.

## Operation
- Reset values: `grant_valid`=0, `grant_idx`=0, `grant_onehot`=0, `timeout`=0, `pending`=0. The fairness pointer `ptr`=0, the timer=0, and the state is IDLE.
- Pending update each cycle: `pending_next = (pending & ~clr) | req`.
  - `clr` is the one-hot of `grant_idx` on the ack cycle and zero otherwise.
  - If a set and a clear hit the same bit in the same cycle, the set wins.
- Selection is combinational:
  - Rotate `pending` right by `ptr`.
  - Encode the lowest set bit of the rotated vector to `off`.
  - Selected index = (`ptr` + `off`) mod 2**N, using an N-bit add with natural wrap.
  - The selection is valid only when `pending` is non-zero.
- State machine, registered, two states:
  - IDLE:
    - If `enable` and `pending` is non-zero: register the selected index into `grant_idx`, set `grant_valid`=1, clear the timer, and go to GRANT.
    - Otherwise stay in IDLE.
  - GRANT, checked in priority order:
    1. `!enable`: `grant_valid`=0, go to IDLE. `pending` and `ptr` are unchanged.
    2. `ack`: clear the pending bit, `ptr` = `grant_idx`+1 (mod 2**N), `grant_valid`=0, go to IDLE.
    3. Timer = `TIMEOUT`-1: pulse `timeout`, `grant_valid`=0, `ptr` = `grant_idx`+1. The pending bit stays set. Go to IDLE.
    4. Otherwise increment the timer.
- `grant_idx` holds its last value after the grant drops; `grant_onehot` is zero whenever `grant_valid`=0.
- `ack` while in IDLE is ignored.
- A grant never changes index mid-grant. New requests only accumulate in `pending`.

## Timing
- `req` sampled high at edge k: the bit appears in `pending` after edge k. If the scheduler is idle and enabled, `grant_valid` rises after edge k+1.
- `ack` sampled at edge j: `grant_valid` is low after edge j. The earliest next grant is after edge j+1, so there is one idle bubble between grants.
- Timeout: grant asserted after edge g with no `ack` means `grant_valid` falls and `timeout` pulses after edge g+`TIMEOUT`.
- Asserting `rst_n` low mid-grant clears all state immediately and asynchronously, and pending requests are lost. Release is synchronous to `clk`.
- All outputs are registered except `grant_onehot` (decoded from registered `grant_idx` and `grant_valid`).

## Structure
- Shared package `sched_pkg`:
  - State encoding constants `ST_IDLE`, `ST_GRANT`.
  - The function for the requester count, 2**N.
- Sub-module `lsb_index_encoder`:
  - Parameter `N`; inputs `in[2**N-1:0]`; outputs `idx[N-1:0]` and `any`.
  - Purely combinational; `idx` is the lowest set bit of `in`.
  - `idx`=0 and `any`=0 when `in` is zero.
  - The top level instantiates it once on the rotated vector.

## Test plan
1. N=3, `req`=8'b0010_0100 for one cycle, `ptr`=0, `ack` on the second grant cycle each time → grants idx 2, then 5. `ptr` ends at 6. `pending` ends at 0.
2. Fairness: `req` held at 8'b1000_0001, `ack` 1 cycle after every grant → idx sequence 0, 7, 0, 7. There is one idle cycle between grants.
3. Wrap-around: `ptr`=7 (reached after a grant to idx 6), pending=8'b0000_0011 → grant idx 0, then idx 1.
4. Timeout: TIMEOUT=4, single request on idx 3, no `ack` → `grant_valid` high for 4 cycles and `timeout` pulses once. `pending[3]` stays 1. The next grant goes to idx 3 again only if no other bit is pending; with bit 1 also pending, idx 1 is granted first because `ptr` moves to 4.
5. Simultaneous `ack` and `req` on the granted bit idx 2 → `pending[2]` stays 1 and idx 2 is regranted after the pointer sweep.
6. `enable` dropped during a grant to idx 4 → `grant_valid`=0 next cycle, `pending[4]`=1, `ptr` unchanged. Asserting `rst_n` low mid-grant clears all outputs in the same cycle, without waiting for an edge.
